dense_ternary_mac: RTL and testbench

Downstream consumer of the dense-layer weight ROM: streams one signed activation per accepted beat, drives the ROM `readAddr` with the activation index, and applies the 10 ternary weights packed in each 20-bit ROM word to 10 parallel accumulators. After 128 activations it drains the 10 dot products serially to the next layer over a valid/ready handshake, then clears for the next frame.

---
 rtl/dense_pkg.sv | 32 +++
 rtl/ternary_lane_acc.sv | 45 ++++
 rtl/dense_ternary_mac.sv | 147 ++++++++++++++
 tb/tb_dense_ternary_mac.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// ============================================================================
// Module   : dense_pkg
// Purpose  : Shared constants, ternary weight encoding and FSM states for
//            dense_ternary_mac.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dense_pkg;

    localparam int IN_W   = 16;
    localparam int LANES  = 10;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ACC_W  = IN_W + ADDR_W + 1;
    localparam int IDX_W  = 4;
    localparam int ROM_W  = 2 * LANES;

    // 2'b10 is reserved and decodes as zero, same as W_ZERO
    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        LAST  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ternary_lane_acc.sv
// ============================================================================
// Module   : ternary_lane_acc
// Purpose  : One output neuron: ternary weight decode and add/subtract/hold
//            accumulator with synchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ternary_lane_acc
    import dense_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [IN_W-1:0]  act,
    input  logic        [1:0]       weight,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_act_ext;

    // Widening before the add keeps -1 x -32768 exact (+32768)
    assign w_act_ext = {{(ACC_W-IN_W){act[IN_W-1]}}, act};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (enable) begin
            case (weight)
                W_POS:   r_acc <= r_acc + w_act_ext;
                W_NEG:   r_acc <= r_acc - w_act_ext;
                default: r_acc <= r_acc;
            endcase
        end
    end

    assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/dense_ternary_mac.sv
// ============================================================================
// Module   : dense_ternary_mac
// Purpose  : Streams 128 activations against ternary ROM weights into 10
//            parallel accumulators, then drains the dot products serially.
//            Optional macro DENSE_TERNARY_RELU_EN clamps negative outputs to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dense_ternary_mac
    import dense_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);

    state_t                  r_state;
    logic [ADDR_W-1:0]       r_count;
    logic signed [IN_W-1:0]  r_act;
    logic                    r_act_valid;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_out_last;

    logic                    w_accept;
    logic                    w_drain_hs;
    logic                    w_clear;
    logic signed [ACC_W-1:0] w_acc [LANES];
    logic signed [ACC_W-1:0] w_sel;

    assign w_accept   = in_valid & r_in_ready;
    assign w_drain_hs = r_out_valid & out_ready;
    assign w_clear    = w_drain_hs & (r_idx == IDX_W'(LANES-1));

    // Activation pipeline: act_q lines up with the ROM word one cycle later
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_act       <= '0;
            r_act_valid <= 1'b0;
        end else begin
            r_act_valid <= w_accept;
            if (w_accept) begin
                r_act <= in_data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ACCUM;
            r_count     <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        if (r_count == ADDR_W'(DEPTH-1)) begin
                            r_count    <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= LAST;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                LAST: begin
                    r_idx       <= '0;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (LANES == 1);
                    r_state     <= DRAIN;
                end
                DRAIN: begin
                    if (w_clear) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ACCUM;
                    end else if (w_drain_hs) begin
                        r_idx      <= r_idx + 1'b1;
                        r_out_last <= (r_idx == IDX_W'(LANES-2));
                    end
                end
                default: begin
                    r_state     <= ACCUM;
                    r_count     <= '0;
                    r_idx       <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            ternary_lane_acc u_lane (
                .clock   (clock),
                .reset_n (reset_n),
                .clear   (w_clear),
                .enable  (r_act_valid),
                .act     (r_act),
                .weight  (rom_data[2*k +: 2]),
                .acc     (w_acc[k])
            );
        end
    endgenerate

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel = w_acc[k];
            end
        end
    end

`ifdef DENSE_TERNARY_RELU_EN
    assign out_data = w_sel[ACC_W-1] ? '0 : w_sel;
`else
    assign out_data = w_sel;
`endif

    assign in_ready  = r_in_ready;
    assign rom_addr  = r_count;
    assign out_valid = r_out_valid;
    assign out_idx   = r_idx;
    assign out_last  = r_out_last;

endmodule

`default_nettype wire

// File: tb/tb_dense_ternary_mac.sv
// ============================================================================
// Module   : tb_dense_ternary_mac
// Purpose  : Directed frames against a behavioural 1-cycle ROM; expected dot
//            products queued at issue time and popped by an output monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dense_ternary_mac;

    localparam int LANES = 10;
    localparam int DEPTH = 128;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [6:0]  rom_addr;
    logic [19:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [19:0] rom_mem [DEPTH];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        held;
    logic [23:0] h_data;
    logic [3:0]  h_idx;
    logic        h_last;

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    dense_ternary_mac dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic int tern(input logic [1:0] w);
        if (w == 2'b01) return 1;
        if (w == 2'b11) return -1;
        return 0;
    endfunction

    // Output monitor: scoreboard pop on handshake, stability while stalled
    always @(negedge clock) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_low_while_draining", in_ready, 0);
                if (held) begin
                    check("stall_data_stable", out_data, h_data);
                    check("stall_idx_stable", out_idx, h_idx);
                    check("stall_last_stable", out_last, h_last);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_idx", out_idx, e.idx);
                    check("out_last", out_last, e.last);
                end
            end
            held   = out_valid && !out_ready;
            h_data = out_data;
            h_idx  = out_idx;
            h_last = out_last;
        end
    end

    task automatic run_frame(input logic [19:0] w_even, input logic [19:0] w_odd,
                             input bit rand_w, input int base, input int step,
                             input bit bubbles, input int stall_at);
        longint      sum [LANES];
        logic signed [15:0] a;
        logic [19:0] word;
        int          i;
        int          guard;
        for (int k = 0; k < LANES; k++) sum[k] = 0;
        for (int j = 0; j < DEPTH; j++) begin
            rom_mem[j] = rand_w ? 20'($urandom) : ((j % 2) ? w_odd : w_even);
            word = rom_mem[j];
            a = 16'(base + j * step);
            for (int k = 0; k < LANES; k++) sum[k] += longint'(a) * tern(word[2*k +: 2]);
        end
        for (int k = 0; k < LANES; k++) begin
            exp_t e;
`ifdef DENSE_TERNARY_RELU_EN
            if (sum[k] < 0) sum[k] = 0;
`endif
            e.data = 24'(sum[k]);
            e.idx  = 4'(k);
            e.last = (k == LANES - 1);
            sb.push_back(e);
        end

        i = 0;
        guard = 0;
        while (i < DEPTH && guard < 2000) begin
            guard++;
            if (bubbles && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = 16'(base + i * step);
                if (i % 16 == 0 || i == DEPTH - 1) check("rom_addr_tracks_beat", rom_addr, i);
                i++;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        if (i < DEPTH) check("stimulus_timeout", i, DEPTH);

        check("last_out_valid", out_valid, 0);
        check("last_in_ready", in_ready, 0);
        @(posedge clock); #1;
        check("drain_out_valid", out_valid, 1);

        if (stall_at >= 0) begin
            repeat (stall_at) @(posedge clock);
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clock);
            #1;
            out_ready = 1'b1;
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clock);
            guard++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        #1;
        check("frame_end_in_ready", in_ready, 1);
        check("frame_end_out_valid", out_valid, 0);
        check("frame_end_rom_addr", rom_addr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        held      = 1'b0;
        for (int j = 0; j < DEPTH; j++) rom_mem[j] = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // All +1 weights, activation +1: every lane 128
        run_frame(20'h55555, 20'h55555, 1'b0, 1, 0, 1'b0, -1);
        // All -1 weights, activation -32768: +4194304 with no wrap
        run_frame(20'hFFFFF, 20'hFFFFF, 1'b0, -32768, 0, 1'b0, -1);
        // Reserved and zero codes interleaved: all lanes 0
        run_frame(20'hAAAAA, 20'h00000, 1'b0, 1000, 0, 1'b0, -1);
        // All -1 weights, activation +5: -640, clamped to 0 under ReLU
        run_frame(20'hFFFFF, 20'hFFFFF, 1'b0, 5, 0, 1'b0, -1);
        // Input bubbles plus a 5-cycle output stall at lane 3
        run_frame(20'h55555, 20'h55555, 1'b0, 1, 0, 1'b1, 3);
        // Per-lane mixed weights and varying activations with bubbles
        run_frame(20'h0, 20'h0, 1'b1, -300, 7, 1'b1, 6);

        // Abort a frame after 50 accepts; the next frame must not inherit it
        for (int j = 0; j < DEPTH; j++) rom_mem[j] = 20'h55555;
        in_valid = 1'b1;
        in_data  = 16'd1;
        repeat (50) @(posedge clock);
        #1;
        check("pre_reset_rom_addr", rom_addr, 50);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_reset_rom_addr", rom_addr, 0);
        check("mid_reset_out_valid", out_valid, 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post_reset_rom_addr", rom_addr, 0);
        check("post_reset_in_ready", in_ready, 1);
        run_frame(20'h55555, 20'h55555, 1'b0, 1, 0, 1'b0, -1);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
